// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the two-port XOR arbiter.
package xor_arb_pkg;

    localparam int   DATA_W  = 32;
    localparam logic REQ0_ID = 1'b0;
    localparam logic REQ1_ID = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/xor_32.sv
// Plain 32-bit bitwise XOR datapath shared by the arbiter.
module xor_32 (
    output logic [31:0] result,
    input  logic [31:0] a,
    input  logic [31:0] b
);

    assign result = a ^ b;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin sharing of one xor_32 between two valid/ready requesters.
// Define XOR_ARB_STATS_EN to add saturating per-requester completion counters.
module xor_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,
    output logic              busy
`ifdef XOR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  ops0_cnt,
    output logic [CNT_W-1:0]  ops1_cnt
`endif
);

    import xor_arb_pkg::*;

    if (DATA_W != xor_arb_pkg::DATA_W) begin : g_bad_data_w
        $error("xor_share_arbiter: DATA_W must be 32 to match xor_32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("xor_share_arbiter: CNT_W must be at least 1");
    end

    state_t              state;
    state_t              state_next;
    logic                last_grant;
    logic                grant_id;
    logic                in_idle;
    logic                accept;
    logic                resp_done;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                op_id;
    logic [DATA_W-1:0]   xor_out;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_id = REQ0_ID;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = REQ1_ID;
        end
    end

    assign in_idle    = (state == IDLE) && rst_n;
    assign req0_ready = in_idle && req0_valid && (grant_id == REQ0_ID);
    assign req1_ready = in_idle && req1_valid && (grant_id == REQ1_ID);
    assign accept     = req0_ready || req1_ready;
    assign resp_done  = (state == RESP) && resp_ready;
    assign busy       = (state == EXEC) || (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? EXEC : IDLE;
            EXEC:    state_next = RESP;
            RESP:    state_next = resp_done ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    xor_32 u_xor (
        .result (xor_out),
        .a      (op_a),
        .b      (op_b)
    );

    // Response stays frozen in RESP until the consumer handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= REQ0_ID;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= REQ0_ID;
            last_grant <= REQ1_ID;
        end else begin
            if (accept) begin
                op_a  <= (grant_id == REQ1_ID) ? req1_a : req0_a;
                op_b  <= (grant_id == REQ1_ID) ? req1_b : req0_b;
                op_id <= grant_id;
            end
            if (state == EXEC) begin
                resp_data  <= xor_out;
                resp_id    <= op_id;
                resp_valid <= 1'b1;
            end
            if (resp_done) begin
                resp_valid <= 1'b0;
                last_grant <= resp_id;
            end
        end
    end

`ifdef XOR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops0_cnt <= '0;
            ops1_cnt <= '0;
        end else if (resp_done) begin
            if (resp_id == REQ0_ID && ops0_cnt != '1) begin
                ops0_cnt <= ops0_cnt + 1'b1;
            end
            if (resp_id == REQ1_ID && ops1_cnt != '1) begin
                ops1_cnt <= ops1_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter using a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_xor_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic        busy;
`ifdef XOR_ARB_STATS_EN
    logic [15:0] ops0_cnt, ops1_cnt;
    logic [1:0]  sat0_cnt, sat1_cnt;
    logic        sat_req0_ready, sat_req1_ready, sat_resp_valid, sat_resp_id, sat_busy;
    logic [31:0] sat_resp_data;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit last_served;

    always #5 clk = ~clk;

    xor_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
`ifdef XOR_ARB_STATS_EN
        ,
        .ops0_cnt   (ops0_cnt),
        .ops1_cnt   (ops1_cnt)
`endif
    );

`ifdef XOR_ARB_STATS_EN
    xor_share_arbiter #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (sat_req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (sat_req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (sat_resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (sat_resp_data),
        .resp_id    (sat_resp_id),
        .busy       (sat_busy),
        .ops0_cnt   (sat0_cnt),
        .ops1_cnt   (sat1_cnt)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        last_served = 1'b1;
    endtask

    // Waits for resp_valid with a bound; returns the number of edges taken.
    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 4) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F;
        req1_a = 32'hDEAD_BEEF; req1_b = 32'h1111_1111;
        tick();
        tick();
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %0b expected 0", resp_valid); end
        n_cmp++; if (resp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_resp_data: got %h expected 00000000", resp_data); end
        n_cmp++; if (resp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_id: got %0b expected 0", resp_id); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req0_ready: got %0b expected 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req1_ready: got %0b expected 0", req1_ready); end
        idle_inputs();
        rst_n = 1'b1;
        last_served = 1'b1;
    endtask

    task automatic test_single();
        int cyc;
        req0_valid = 1'b1;
        req0_a = 32'h0000_0039;
        req0_b = 32'h0000_0003;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_req0_ready: got %0b expected 1", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL single_req1_ready: got %0b expected 0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_exec: got busy=%0b resp_valid=%0b expected busy=1 resp_valid=0", busy, resp_valid); end
        wait_resp(cyc);
        n_cmp++; if (cyc != 1) begin n_fail++; $display("[TB] FAIL single_latency: got %0d edges expected 1", cyc); end
        n_cmp++; if (resp_data !== 32'h0000_003A) begin n_fail++; $display("[TB] FAIL single_data: got %h expected 0000003a", resp_data); end
        n_cmp++; if (resp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL single_id: got %0b expected 0", resp_id); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        last_served = 1'b0;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_consume: got resp_valid=%0b busy=%0b expected 0 0", resp_valid, busy); end
    endtask

    task automatic test_tie();
        int cyc;
        logic [31:0] a0, b0;
        do_reset();
        a0 = $urandom; b0 = $urandom;
        req0_valid = 1'b1; req0_a = a0; req0_b = b0;
        req1_valid = 1'b1; req1_a = 32'h2; req1_b = 32'h1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL tie_first_grant: got ready0=%0b ready1=%0b expected 1 0", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        wait_resp(cyc);
        n_cmp++; if (resp_id !== 1'b0 || resp_data !== (a0 ^ b0)) begin n_fail++; $display("[TB] FAIL tie_first_resp: got id=%0b data=%h expected id=0 data=%h", resp_id, resp_data, a0 ^ b0); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL tie_second_grant: got ready1=%0b expected 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        wait_resp(cyc);
        n_cmp++; if (resp_id !== 1'b1 || resp_data !== 32'h3) begin n_fail++; $display("[TB] FAIL tie_second_resp: got id=%0b data=%h expected id=1 data=00000003", resp_id, resp_data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        last_served = 1'b1;
    endtask

    task automatic test_fairness();
        int acc_cycle[$];
        int n_resp;
        bit exp_id;
        logic [31:0] a0, b0, a1, b1, exp_data;
        do_reset();
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        n_resp = 0;
        #1;
        for (int c = 0; c < 60 && n_resp < 8; c++) begin
            if (req0_ready === 1'b1 || req1_ready === 1'b1) acc_cycle.push_back(c);
            if (resp_valid === 1'b1) begin
                exp_id = ~last_served;
                last_served = exp_id;
                exp_data = exp_id ? (a1 ^ b1) : (a0 ^ b0);
                n_cmp++; if (resp_id !== exp_id || resp_data !== exp_data) begin n_fail++; $display("[TB] FAIL fair_resp%0d: got id=%0b data=%h expected id=%0b data=%h", n_resp, resp_id, resp_data, exp_id, exp_data); end
                n_resp++;
            end
            tick();
        end
        idle_inputs();
        n_cmp++; if (n_resp != 8) begin n_fail++; $display("[TB] FAIL fair_count: got %0d responses expected 8", n_resp); end
        for (int i = 1; i < acc_cycle.size(); i++) begin
            n_cmp++; if (acc_cycle[i] - acc_cycle[i-1] != 3) begin n_fail++; $display("[TB] FAIL fair_gap%0d: got %0d cycles expected 3", i, acc_cycle[i] - acc_cycle[i-1]); end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0F0F_0F0F;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
        tick();
        req0_valid = 1'b0;
        wait_resp(cyc);
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 32'hF0F0_F0F0) begin n_fail++; $display("[TB] FAIL bp_hold%0d: got valid=%0b data=%h expected 1 f0f0f0f0", k, resp_valid, resp_data); end
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready%0d: got %0b%0b expected 00", k, req0_ready, req1_ready); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_busy%0d: got %0b expected 1", k, busy); end
            tick();
        end
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        last_served = 1'b0;
    endtask

    task automatic test_reset_mid();
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
        tick();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_cmp++; if (resp_valid !== 1'b0 || resp_data !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_state: got valid=%0b data=%h busy=%0b expected 0 00000000 0", resp_valid, resp_data, busy); end
        rst_n = 1'b1;
        last_served = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_stale%0d: got valid=%0b busy=%0b expected 0 0", k, resp_valid, busy); end
        end
    endtask

    task automatic test_random(input int n_ops);
        int cyc, hold;
        bit v0, v1, w;
        logic [31:0] a0, b0, a1, b1, exp_data;
        for (int n = 0; n < n_ops; n++) begin
            v0 = $urandom_range(0, 1);
            v1 = $urandom_range(0, 1);
            if (!v0 && !v1) v0 = 1'b1;
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            w = (v0 && v1) ? ~last_served : v1;
            exp_data = w ? (a1 ^ b1) : (a0 ^ b0);
            req0_valid = v0; req0_a = a0; req0_b = b0;
            req1_valid = v1; req1_a = a1; req1_b = b1;
            #1;
            n_cmp++; if (req0_ready !== !w || req1_ready !== w) begin n_fail++; $display("[TB] FAIL rand_grant%0d: got %0b%0b expected winner %0b", n, req1_ready, req0_ready, w); end
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_resp(cyc);
            n_cmp++; if (cyc != 1 || resp_id !== w || resp_data !== exp_data) begin n_fail++; $display("[TB] FAIL rand_resp%0d: got lat=%0d id=%0b data=%h expected lat=1 id=%0b data=%h", n, cyc, resp_id, resp_data, w, exp_data); end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                tick();
                n_cmp++; if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_id !== w) begin n_fail++; $display("[TB] FAIL rand_hold%0d: got valid=%0b id=%0b data=%h expected 1 %0b %h", n, resp_valid, resp_id, resp_data, w, exp_data); end
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            last_served = w;
            n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_consume%0d: got %0b expected 0", n, resp_valid); end
        end
    endtask

`ifdef XOR_ARB_STATS_EN
    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        cyc = 0;
        while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && cyc < 4) begin
            tick();
            cyc++;
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(cyc);
        n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL run_op_timeout: got resp_valid=%0b expected 1", resp_valid); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) run_op(1'b0, $urandom, $urandom);
        run_op(1'b1, $urandom, $urandom);
        n_cmp++; if (ops0_cnt !== 16'd3 || ops1_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL stats_count: got %0d %0d expected 3 1", ops0_cnt, ops1_cnt); end
        for (int i = 0; i < 2; i++) run_op(1'b0, $urandom, $urandom);
        n_cmp++; if (ops0_cnt !== 16'd5) begin n_fail++; $display("[TB] FAIL stats_count5: got %0d expected 5", ops0_cnt); end
        n_cmp++; if (sat0_cnt !== 2'd3 || sat1_cnt !== 2'd1) begin n_fail++; $display("[TB] FAIL stats_saturate: got %0d %0d expected 3 1", sat0_cnt, sat1_cnt); end
        last_served = 1'b0;
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random(30);
`ifdef XOR_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
